y86_fde_stages: RTL and testbench



---
 rtl/y86_fde_stages.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_y86_fde_stages.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fde_stages.sv
// y86_fde_stages
// Fetch, decode/write-back and execute stage logic of the five-stage
// pipelined Y86-64 core, together with the state these stages own:
// the predicted-PC register, the 15-entry register file and the
// condition codes {ZF,SF,OF}.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   imem_bytes/imem_error : 10-byte instruction window at f_pc, address fault
//   F_stall               : hold the predicted-PC register
//   D_* / E_* / M_* / W_* : fields of the external pipeline registers
//   m_valM                : data-memory read value of the memory stage
//   set_cc                : condition-code write enable from pipeline control
//   f_*                   : combinational fetch results
//   d_*                   : decode sources/destinations and forwarded operands
//   e_valE/e_cnd/e_dstE   : ALU result, branch/move condition, gated destination
module y86_fde_stages (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] imem_bytes,
  input  logic        imem_error,
  input  logic        F_stall,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [3:0]  E_dstE,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic        set_cc,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic [63:0] f_pc,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic [63:0] f_predPC,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [1:0]  f_stat,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [63:0] e_valE,
  output logic        e_cnd,
  output logic [3:0]  e_dstE
);

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] R_RSP   = 4'h4;
  localparam logic [3:0] R_NONE  = 4'hF;

  localparam logic [1:0] S_AOK   = 2'b00;
  localparam logic [1:0] S_ADR   = 2'b01;
  localparam logic [1:0] S_INS   = 2'b10;
  localparam logic [1:0] S_HLT   = 2'b11;

  // D_ifun and D_valC pass straight through the external D/E register.
  logic unused_inputs;
  assign unused_inputs = ^{D_ifun, D_valC};

  // ---------------------------------------------------------------- state
  logic [63:0] pred_pc;
  logic [63:0] regs [15];
  logic        zf, sf, of;

  // ---------------------------------------------------------------- fetch
  logic [3:0] raw_icode;
  logic       need_regids;
  logic       valc_at_byte1;
  logic       valc_at_byte2;

  always_comb begin
    if (M_icode == I_JXX && !M_Cnd)
      f_pc = M_valA;
    else if (W_icode == I_RET)
      f_pc = W_valM;
    else
      f_pc = pred_pc;
  end

  assign raw_icode = imem_bytes[7:4];
  assign f_icode   = imem_error ? I_NOP : raw_icode;
  assign f_ifun    = imem_error ? 4'h0  : imem_bytes[3:0];

  always_comb begin
    need_regids   = 1'b0;
    valc_at_byte1 = 1'b0;
    valc_at_byte2 = 1'b0;
    case (f_icode)
      I_RRMOV, I_OP, I_PUSH, I_POP: need_regids = 1'b1;
      I_IRMOV, I_RMMOV, I_MRMOV: begin
        need_regids   = 1'b1;
        valc_at_byte2 = 1'b1;
      end
      I_JXX, I_CALL: valc_at_byte1 = 1'b1;
      default: ;
    endcase
  end

  assign f_rA = need_regids ? imem_bytes[15:12] : R_NONE;
  assign f_rB = need_regids ? imem_bytes[11:8]  : R_NONE;

  always_comb begin
    f_valC = '0;
    if (valc_at_byte2)
      f_valC = imem_bytes[79:16];
    else if (valc_at_byte1)
      f_valC = imem_bytes[71:8];
  end

  assign f_valP = f_pc + 64'd1 + {63'd0, need_regids}
                + ((valc_at_byte1 || valc_at_byte2) ? 64'd8 : 64'd0);

  always_comb begin
    if (imem_error)
      f_stat = S_ADR;
    else if (raw_icode > I_POP)
      f_stat = S_INS;
    else if (raw_icode == I_HALT)
      f_stat = S_HLT;
    else
      f_stat = S_AOK;
  end

  assign f_predPC = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pred_pc <= '0;
    else if (!F_stall)
      pred_pc <= f_predPC;
  end

  // --------------------------------------------------------------- decode
  always_comb begin
    case (D_icode)
      I_RRMOV, I_RMMOV, I_OP, I_PUSH: d_srcA = D_rA;
      I_POP, I_RET:                   d_srcA = R_RSP;
      default:                        d_srcA = R_NONE;
    endcase
    case (D_icode)
      I_OP, I_RMMOV, I_MRMOV:         d_srcB = D_rB;
      I_PUSH, I_POP, I_CALL, I_RET:   d_srcB = R_RSP;
      default:                        d_srcB = R_NONE;
    endcase
    case (D_icode)
      I_RRMOV, I_IRMOV, I_OP:         d_dstE = D_rB;
      I_PUSH, I_POP, I_CALL, I_RET:   d_dstE = R_RSP;
      default:                        d_dstE = R_NONE;
    endcase
    case (D_icode)
      I_MRMOV, I_POP:                 d_dstM = D_rA;
      default:                        d_dstM = R_NONE;
    endcase
  end

  logic [63:0] rf_a, rf_b;
  assign rf_a = (d_srcA == R_NONE) ? '0 : regs[d_srcA];
  assign rf_b = (d_srcB == R_NONE) ? '0 : regs[d_srcB];

  // Forwarding priority: youngest producer first; RNONE sources never
  // match because they short-circuit to zero ahead of the chain.
  always_comb begin
    if (D_icode == I_CALL || D_icode == I_JXX)
      d_valA = D_valP;
    else if (d_srcA == R_NONE)
      d_valA = '0;
    else if (d_srcA == e_dstE)
      d_valA = e_valE;
    else if (d_srcA == M_dstM)
      d_valA = m_valM;
    else if (d_srcA == M_dstE)
      d_valA = M_valE;
    else if (d_srcA == W_dstM)
      d_valA = W_valM;
    else if (d_srcA == W_dstE)
      d_valA = W_valE;
    else
      d_valA = rf_a;
  end

  always_comb begin
    if (d_srcB == R_NONE)
      d_valB = '0;
    else if (d_srcB == e_dstE)
      d_valB = e_valE;
    else if (d_srcB == M_dstM)
      d_valB = m_valM;
    else if (d_srcB == M_dstE)
      d_valB = M_valE;
    else if (d_srcB == W_dstM)
      d_valB = W_valM;
    else if (d_srcB == W_dstE)
      d_valB = W_valE;
    else
      d_valB = rf_b;
  end

  // The valM write is issued last so it overrides valE on a shared target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 15; i++)
        regs[i] <= '0;
    end else begin
      if (W_dstE != R_NONE)
        regs[W_dstE] <= W_valE;
      if (W_dstM != R_NONE)
        regs[W_dstM] <= W_valM;
    end
  end

  // -------------------------------------------------------------- execute
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_of;

  always_comb begin
    case (E_icode)
      I_RRMOV, I_OP:            alu_a = E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
      I_CALL, I_PUSH:           alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POP:             alu_a = 64'd8;
      default:                  alu_a = '0;
    endcase
  end

  assign alu_b   = (E_icode == I_RRMOV || E_icode == I_IRMOV) ? '0 : E_valB;
  assign alu_fun = (E_icode == I_OP) ? E_ifun : 4'h0;

  always_comb begin
    e_valE = alu_b + alu_a;
    alu_of = (alu_a[63] == alu_b[63]) && (e_valE[63] != alu_b[63]);
    case (alu_fun)
      4'h1: begin
        e_valE = alu_b - alu_a;
        alu_of = (alu_a[63] != alu_b[63]) && (e_valE[63] != alu_b[63]);
      end
      4'h2: begin
        e_valE = alu_b & alu_a;
        alu_of = 1'b0;
      end
      4'h3: begin
        e_valE = alu_b ^ alu_a;
        alu_of = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (E_icode == I_OP && set_cc) begin
      zf <= (e_valE == 64'd0);
      sf <= e_valE[63];
      of <= alu_of;
    end
  end

  logic cond;
  always_comb begin
    case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = ~zf;
      4'h5:    cond = ~(sf ^ of);
      4'h6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

  assign e_cnd  = (E_icode == I_JXX || E_icode == I_RRMOV) ? cond : 1'b1;
  assign e_dstE = (E_icode == I_RRMOV && !e_cnd) ? R_NONE : E_dstE;

endmodule

// File: tb/tb_y86_fde_stages.sv
// Scoreboard bench for y86_fde_stages: stimulus drives a vector just after
// the rising edge and queues the hand-computed expectations; the monitor
// pops and compares them at the following falling edge.
module tb_y86_fde_stages;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] imem_bytes;
  logic        imem_error, F_stall;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  E_icode, E_ifun, E_dstE;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        set_cc;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valA, M_valE, m_valM;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [63:0] f_pc, f_valC, f_valP, f_predPC;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [1:0]  f_stat;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, e_valE;
  logic        e_cnd;
  logic [3:0]  e_dstE;

  y86_fde_stages dut (
    .clk(clk), .reset(reset), .imem_bytes(imem_bytes), .imem_error(imem_error),
    .F_stall(F_stall), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_dstE(E_dstE), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .set_cc(set_cc), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_Cnd(M_Cnd), .M_valA(M_valA), .M_valE(M_valE), .m_valM(m_valM),
    .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE),
    .W_valM(W_valM), .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP),
    .f_predPC(f_predPC), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA),
    .f_rB(f_rB), .f_stat(f_stat), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB),
    .e_valE(e_valE), .e_cnd(e_cnd), .e_dstE(e_dstE)
  );

  always #5 clk = ~clk;

  localparam int S_FPC = 0, S_FVALC = 1, S_FVALP = 2, S_FPRED = 3, S_FICODE = 4,
                 S_FIFUN = 5, S_FRA = 6, S_FRB = 7, S_FSTAT = 8, S_SRCA = 9,
                 S_SRCB = 10, S_DSTE = 11, S_DSTM = 12, S_VALA = 13, S_VALB = 14,
                 S_EVALE = 15, S_ECND = 16, S_EDSTE = 17;

  typedef struct {
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] sig_val(input int s);
    case (s)
      S_FPC:    return f_pc;
      S_FVALC:  return f_valC;
      S_FVALP:  return f_valP;
      S_FPRED:  return f_predPC;
      S_FICODE: return {60'd0, f_icode};
      S_FIFUN:  return {60'd0, f_ifun};
      S_FRA:    return {60'd0, f_rA};
      S_FRB:    return {60'd0, f_rB};
      S_FSTAT:  return {62'd0, f_stat};
      S_SRCA:   return {60'd0, d_srcA};
      S_SRCB:   return {60'd0, d_srcB};
      S_DSTE:   return {60'd0, d_dstE};
      S_DSTM:   return {60'd0, d_dstM};
      S_VALA:   return d_valA;
      S_VALB:   return d_valB;
      S_EVALE:  return e_valE;
      S_ECND:   return {63'd0, e_cnd};
      S_EDSTE:  return {60'd0, e_dstE};
      default:  return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // Monitor: drains every expectation queued during the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = sig_val(e.sel);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic ex(input int s, input logic [63:0] v, input string n);
    exp_t e;
    e.sel = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic set_defaults();
    imem_bytes = 80'h0A_F2_30;   // irmovq $10,%rdx
    imem_error = 1'b0; F_stall = 1'b1;
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = '0; D_valP = '0;
    E_icode = 4'h1; E_ifun = 4'h0; E_dstE = 4'hF;
    E_valA = '0; E_valB = '0; E_valC = '0; set_cc = 1'b0;
    M_icode = 4'h1; M_dstE = 4'hF; M_dstM = 4'hF; M_Cnd = 1'b1;
    M_valA = '0; M_valE = '0; m_valM = '0;
    W_icode = 4'h1; W_dstE = 4'hF; W_dstM = 4'hF; W_valE = '0; W_valM = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    set_defaults();
  endtask

  initial begin
    reset = 1'b1;
    set_defaults();

    // Reset state and irmovq fetch.
    step();
    ex(S_FPC, 64'd0, "rst_fpc");     ex(S_FICODE, 64'd3, "rst_ficode");
    ex(S_FRA, 64'hF, "rst_frA");     ex(S_FRB, 64'd2, "rst_frB");
    ex(S_FVALC, 64'd10, "rst_fvalC"); ex(S_FVALP, 64'd10, "rst_fvalP");
    ex(S_FPRED, 64'd10, "rst_fpred"); ex(S_FSTAT, 64'd0, "rst_fstat");
    D_icode = 4'h6; D_rA = 4'h0; D_rB = 4'hE;
    ex(S_VALA, 64'd0, "rst_r0");     ex(S_VALB, 64'd0, "rst_r14");
    E_icode = 4'h7; E_ifun = 4'h3;
    ex(S_ECND, 64'd1, "rst_zf_je");

    // Release reset, let the predicted PC load once.
    step();
    reset = 1'b0; F_stall = 1'b0;
    step();
    ex(S_FPC, 64'd10, "predpc_load");

    // PC selection.
    step();
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h40;
    ex(S_FPC, 64'h40, "mispredict_pc");
    step();
    W_icode = 4'h9; W_valM = 64'h80;
    ex(S_FPC, 64'h80, "ret_pc");

    // Fetch formats (pc = 10).
    step();
    imem_bytes = {8'h00, 64'h0000_0000_0000_1234, 8'h70};
    ex(S_FVALC, 64'h1234, "jxx_valC"); ex(S_FVALP, 64'd19, "jxx_valP");
    ex(S_FPRED, 64'h1234, "jxx_pred"); ex(S_FRA, 64'hF, "jxx_rA");
    F_stall = 1'b0;
    step();
    ex(S_FPC, 64'h1234, "jxx_predpc");
    imem_bytes = 80'h23_60;
    ex(S_FVALP, 64'h1236, "op_valP"); ex(S_FVALC, 64'd0, "op_valC");
    ex(S_FRA, 64'd2, "op_rA"); ex(S_FRB, 64'd3, "op_rB");
    ex(S_FPRED, 64'h1236, "op_pred");
    step();
    imem_bytes = 80'hC0;
    ex(S_FSTAT, 64'd2, "ins_stat");
    step();
    imem_error = 1'b1;
    ex(S_FSTAT, 64'd1, "adr_stat"); ex(S_FICODE, 64'd1, "adr_icode");
    ex(S_FIFUN, 64'd0, "adr_ifun");
    step();
    imem_bytes = 80'h00;
    ex(S_FSTAT, 64'd3, "hlt_stat");

    // Decode and forwarding.
    step();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    E_icode = 4'h3; E_dstE = 4'h2; E_valC = 64'd5;
    M_dstE = 4'h3; M_valE = 64'd7;
    ex(S_VALA, 64'd5, "fwd_e_valA"); ex(S_VALB, 64'd7, "fwd_M_valB");
    ex(S_DSTE, 64'd3, "op_dstE"); ex(S_DSTM, 64'hF, "op_dstM");
    ex(S_SRCA, 64'd2, "op_srcA"); ex(S_SRCB, 64'd3, "op_srcB");
    step();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    E_icode = 4'h3; E_dstE = 4'h2; E_valC = 64'd5;
    M_dstM = 4'h2; M_dstE = 4'h3; m_valM = 64'd9; M_valE = 64'd7;
    M_dstM = 4'h3;
    W_dstE = 4'h2; W_valE = 64'h11;
    ex(S_VALA, 64'd5, "prio_e_over_W"); ex(S_VALB, 64'd9, "prio_mM_over_ME");
    step();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    W_dstM = 4'h2; W_valM = 64'h22; W_dstE = 4'h2; W_valE = 64'h33;
    ex(S_VALA, 64'h22, "fwd_WM_over_WE"); ex(S_VALB, 64'd0, "rf_r3_zero");
    step();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    ex(S_VALA, 64'h22, "rf_valM_wins");
    step();
    D_icode = 4'h8; D_valP = 64'h123;
    ex(S_VALA, 64'h123, "call_valP"); ex(S_SRCA, 64'hF, "call_srcA");
    ex(S_SRCB, 64'd4, "call_srcB"); ex(S_DSTE, 64'd4, "call_dstE");
    step();
    D_icode = 4'hB; D_rA = 4'h6;
    ex(S_SRCA, 64'd4, "pop_srcA"); ex(S_DSTM, 64'd6, "pop_dstM");

    // ALU and condition codes.
    step();
    E_icode = 4'h6; E_ifun = 4'h0; E_valA = 64'd1; E_valB = 64'd2; set_cc = 1'b1;
    ex(S_EVALE, 64'd3, "add_1_2");
    step();
    E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h5;
    ex(S_ECND, 64'd0, "cmovle_cc000"); ex(S_EDSTE, 64'hF, "cmovle_dst_none");
    step();
    E_icode = 4'h6; E_ifun = 4'h1; E_valA = 64'd1; E_valB = 64'd1; set_cc = 1'b1;
    ex(S_EVALE, 64'd0, "sub_zero");
    step();
    E_icode = 4'h7; E_ifun = 4'h3;
    ex(S_ECND, 64'd1, "je_after_zero");
    step();
    E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h5;
    ex(S_ECND, 64'd1, "cmovle_zf"); ex(S_EDSTE, 64'd5, "cmovle_dst");
    step();
    E_icode = 4'h6; E_ifun = 4'h0; set_cc = 1'b1;
    E_valA = 64'h7FFF_FFFF_FFFF_FFFF; E_valB = 64'h7FFF_FFFF_FFFF_FFFF;
    ex(S_EVALE, 64'hFFFF_FFFF_FFFF_FFFE, "add_ovf");
    step();
    E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h5;
    ex(S_ECND, 64'd0, "cmovle_sf_of"); ex(S_EDSTE, 64'hF, "cmovle_ovf_none");
    step();
    E_icode = 4'h2; E_ifun = 4'h6; E_dstE = 4'h5;
    ex(S_ECND, 64'd1, "cmovg_sf_of"); ex(S_EDSTE, 64'd5, "cmovg_dst");
    step();
    E_icode = 4'h6; E_ifun = 4'h2; E_valA = 64'hF0F0; E_valB = 64'hFF00;
    ex(S_EVALE, 64'hF000, "and");
    step();
    E_icode = 4'h6; E_ifun = 4'h3; E_valA = 64'hF0F0; E_valB = 64'hFF00;
    ex(S_EVALE, 64'h0FF0, "xor");
    step();
    E_icode = 4'h6; E_ifun = 4'h1; E_valA = 64'd1; E_valB = 64'h8000_0000_0000_0000;
    ex(S_EVALE, 64'h7FFF_FFFF_FFFF_FFFF, "sub_wrap");
    step();
    E_icode = 4'h5; E_valC = 64'h10; E_valB = 64'h100;
    ex(S_EVALE, 64'h110, "mrmov_addr");
    step();
    E_icode = 4'hA; E_valB = 64'h100;
    ex(S_EVALE, 64'hF8, "push_sp"); ex(S_ECND, 64'd1, "push_cnd");
    step();
    E_icode = 4'hB; E_valB = 64'h100;
    ex(S_EVALE, 64'h108, "pop_sp");
    step();
    E_icode = 4'h2; E_ifun = 4'h0; E_valA = 64'h55; E_valB = 64'h99; E_dstE = 4'h7;
    ex(S_EVALE, 64'h55, "rrmov"); ex(S_EDSTE, 64'd7, "rrmov_dst");

    // Asynchronous reset mid-run clears PC, registers and CC.
    step();
    reset = 1'b1;
    D_icode = 4'h6; D_rA = 4'h2;
    E_icode = 4'h7; E_ifun = 4'h3;
    ex(S_FPC, 64'd0, "midrst_pc"); ex(S_VALA, 64'd0, "midrst_r2");
    ex(S_ECND, 64'd1, "midrst_zf");
    step();
    reset = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end by 100000");
    $fatal(1);
  end

endmodule
